// File: rtl/sram_port_arbiter.sv
// Three-way arbiter (IO > D > I, with I promoted after MAX_WAIT losses) for a single-port SRAM.
// GNT one cycle after request edge; write done 1 cycle later, read data 2 cycles later; requesters hold REQ until GNT.
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_lock,
  input  logic                  io_req,
  input  logic                  d_req,
  input  logic                  i_req,
  input  logic                  io_we,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  io_gnt,
  output logic                  d_gnt,
  output logic                  i_gnt,
  output logic                  io_rvalid,
  output logic                  d_rvalid,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  cen,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] q
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  typedef enum logic [1:0] {SEL_IO, SEL_D, SEL_I} sel_t;

  localparam logic [CNT_WIDTH-1:0] WAIT_MAX = CNT_WIDTH'(MAX_WAIT);

  state_t                state, state_nxt;
  sel_t                  sel, sel_nxt, win;
  logic                  cen_nxt, wen_nxt;
  logic [ADDR_WIDTH-1:0] a_nxt;
  logic [DATA_WIDTH-1:0] d_nxt, rdata_nxt;
  logic [2:0]            gnt, gnt_nxt, rvalid, rvalid_nxt;
  logic [CNT_WIDTH-1:0]  wait_cnt, cnt_nxt;
  logic                  io_el, d_el, i_el;

  function automatic logic [2:0] onehot(input sel_t s);
    case (s)
      SEL_IO:  onehot = 3'b001;
      SEL_D:   onehot = 3'b010;
      SEL_I:   onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  assign io_el = io_req;
  assign d_el  = ~io_lock & d_req;
  assign i_el  = ~io_lock & i_req;

  // A starved instruction port jumps ahead of the data port, never ahead of IO.
  always_comb begin
    win = SEL_D;
    if (io_el)
      win = SEL_IO;
    else if (i_el && ((wait_cnt == WAIT_MAX) || !d_el))
      win = SEL_I;
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    cen_nxt    = 1'b1;
    wen_nxt    = wen;
    a_nxt      = a;
    d_nxt      = d;
    rdata_nxt  = rdata;
    gnt_nxt    = 3'b000;
    rvalid_nxt = 3'b000;
    cnt_nxt    = wait_cnt;
    case (state)
      IDLE: begin
        if (io_el || d_el || i_el) begin
          case (win)
            SEL_IO: begin
              a_nxt   = io_addr;
              wen_nxt = ~io_we;
              d_nxt   = io_wdata;
            end
            SEL_D: begin
              a_nxt   = d_addr;
              wen_nxt = ~d_we;
              d_nxt   = d_wdata;
            end
            default: begin
              a_nxt   = i_addr;
              wen_nxt = 1'b1;
            end
          endcase
          cen_nxt   = 1'b0;
          gnt_nxt   = onehot(win);
          sel_nxt   = win;
          state_nxt = ISSUE;
          if (win == SEL_I)
            cnt_nxt = '0;
          else if (i_el && (wait_cnt != WAIT_MAX))
            cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ISSUE: state_nxt = wen ? RDWAIT : IDLE;
      RDWAIT: begin
        rdata_nxt  = q;
        rvalid_nxt = onehot(sel);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= SEL_IO;
      cen      <= 1'b1;
      wen      <= 1'b1;
      a        <= '0;
      d        <= '0;
      rdata    <= '0;
      gnt      <= 3'b000;
      rvalid   <= 3'b000;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      cen      <= cen_nxt;
      wen      <= wen_nxt;
      a        <= a_nxt;
      d        <= d_nxt;
      rdata    <= rdata_nxt;
      gnt      <= gnt_nxt;
      rvalid   <= rvalid_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  assign {i_gnt, d_gnt, io_gnt}          = gnt;
  assign {i_rvalid, d_rvalid, io_rvalid} = rvalid;
  assign busy = (state != IDLE);

endmodule
